// File: rtl/udp_pkg.sv
// rtl/udp_pkg.sv - shared UDP transmit types and constants
package udp_pkg;

  localparam int UDP_MAX_SRC = 16;

  typedef struct packed {
    logic [31:0] ip_dest;
    logic [31:0] ip_src;
    logic [15:0] port_dest;
    logic [15:0] port_src;
  } udp_hdr_t;

  typedef struct packed {
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
  } udp_axis_t;

  function automatic int udp_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting after last_winner
// UDP_ARB_PRIO0_EN: request 0 wins outright, the rest rotate among themselves.
module rr_arbiter
  import udp_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = udp_idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_winner,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic          found;
  logic [IW:0]   pos;
  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = |req;
    found   = 1'b0;
    pos     = '0;
    idx     = '0;
`ifdef UDP_ARB_PRIO0_EN
    if (req[0]) begin
      gnt[0] = 1'b1;
      found  = 1'b1;
    end
`endif
    // With priority on, req[0] is low whenever this search can still win, so 0 is skipped
    for (int k = 1; k <= N; k++) begin
      pos = {1'b0, last_winner} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      idx = pos[IW-1:0];
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// rtl/udp_tx_arbiter.sv - packet-level arbiter sharing one UDP tx datapath between sources
// UDP_ARB_PRIO0_EN: source 0 gets strict priority at each arbitration.
module udp_tx_arbiter
  import udp_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_SRC-1:0][31:0] s_hdr_ip_dest_i,
  input  logic [N_SRC-1:0][31:0] s_hdr_ip_src_i,
  input  logic [N_SRC-1:0][15:0] s_hdr_port_dest_i,
  input  logic [N_SRC-1:0][15:0] s_hdr_port_src_i,
  input  logic [N_SRC-1:0][31:0] s_tdata_i,
  input  logic [N_SRC-1:0][3:0]  s_tkeep_i,
  input  logic [N_SRC-1:0]       s_tlast_i,
  input  logic [N_SRC-1:0]       s_tvld_i,
  output logic [N_SRC-1:0]       s_trdy_o,
  output logic [31:0]            m_hdr_ip_dest_o,
  output logic [31:0]            m_hdr_ip_src_o,
  output logic [15:0]            m_hdr_port_dest_o,
  output logic [15:0]            m_hdr_port_src_o,
  output logic [31:0]            m_tdata_o,
  output logic [3:0]             m_tkeep_o,
  output logic                   m_tlast_o,
  output logic                   m_tvld_o,
  input  logic                   m_trdy_i,
  output logic [N_SRC-1:0]       grant_o
);

  localparam int IW = udp_idx_w(N_SRC);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]       state_q;
  logic [N_SRC-1:0] grant_q;
  logic [N_SRC-1:0] arb_gnt;
  logic [IW-1:0]    gidx_q;
  logic [IW-1:0]    last_q;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;
  logic             out_free;
  logic             accept;
  udp_hdr_t         hdr_sel;
  udp_hdr_t         hdr_q;
  udp_axis_t        beat_sel;
  udp_axis_t        beat_q;

  rr_arbiter #(
    .N  (N_SRC),
    .IW (IW)
  ) u_rr_arbiter (
    .req         (s_tvld_i),
    .last_winner (last_q),
    .gnt         (arb_gnt),
    .gnt_idx     (arb_idx),
    .any         (arb_any)
  );

  // grant_q is zero outside SEND, so ready is just the grant gated by output space
  assign out_free = ~m_tvld_o | m_trdy_i;
  assign s_trdy_o = grant_q & {N_SRC{out_free}};
  assign accept   = |(s_tvld_i & s_trdy_o);
  assign grant_o  = grant_q;

  always_comb begin
    hdr_sel.ip_dest   = s_hdr_ip_dest_i[gidx_q];
    hdr_sel.ip_src    = s_hdr_ip_src_i[gidx_q];
    hdr_sel.port_dest = s_hdr_port_dest_i[gidx_q];
    hdr_sel.port_src  = s_hdr_port_src_i[gidx_q];
    beat_sel.tdata    = s_tdata_i[gidx_q];
    beat_sel.tkeep    = s_tkeep_i[gidx_q];
    beat_sel.tlast    = s_tlast_i[gidx_q];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(N_SRC - 1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            grant_q <= arb_gnt;
            gidx_q  <= arb_idx;
            state_q <= ST_SEND;
          end
        end
        default: begin
          if (accept && beat_sel.tlast) begin
            last_q  <= gidx_q;
            grant_q <= '0;
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_tvld_o <= 1'b0;
      hdr_q    <= '0;
      beat_q   <= '0;
    end else if (accept) begin
      m_tvld_o <= 1'b1;
      hdr_q    <= hdr_sel;
      beat_q   <= beat_sel;
    end else if (m_trdy_i) begin
      m_tvld_o <= 1'b0;
    end
  end

  assign m_hdr_ip_dest_o   = hdr_q.ip_dest;
  assign m_hdr_ip_src_o    = hdr_q.ip_src;
  assign m_hdr_port_dest_o = hdr_q.port_dest;
  assign m_hdr_port_src_o  = hdr_q.port_src;
  assign m_tdata_o         = beat_q.tdata;
  assign m_tkeep_o         = beat_q.tkeep;
  assign m_tlast_o         = beat_q.tlast;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb/tb_udp_tx_arbiter.sv - self-checking bench for udp_tx_arbiter
// UDP_ARB_PRIO0_EN selects the strict-priority expectations.
module tb_udp_tx_arbiter;

  localparam int NS = 4;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [NS-1:0][31:0] s_ipd, s_ips, s_td;
  logic [NS-1:0][15:0] s_ppd, s_pps;
  logic [NS-1:0][3:0]  s_tk;
  logic [NS-1:0]       s_tl, s_tv, s_trdy, grant;
  logic [31:0] m_ipd, m_ips, m_td;
  logic [15:0] m_ppd, m_pps;
  logic [3:0]  m_tk;
  logic        m_tl, m_tvld;
  logic        m_trdy = 1'b1;

  logic [31:0] hd_ipd [NS];
  logic [31:0] hd_ips [NS];
  logic [15:0] hd_ppd [NS];
  logic [15:0] hd_pps [NS];
  logic [31:0] td_u [NS];
  logic [3:0]  tk_u [NS];
  logic        tl_u [NS];
  logic        tv_u [NS];
  logic        trdy_u [NS];
  logic        rdy_seen [NS];
  logic        hold [NS];

  udp_tx_arbiter #(.N_SRC(NS)) dut (
    .clk (clk), .reset_n (reset_n),
    .s_hdr_ip_dest_i (s_ipd), .s_hdr_ip_src_i (s_ips),
    .s_hdr_port_dest_i (s_ppd), .s_hdr_port_src_i (s_pps),
    .s_tdata_i (s_td), .s_tkeep_i (s_tk), .s_tlast_i (s_tl), .s_tvld_i (s_tv),
    .s_trdy_o (s_trdy),
    .m_hdr_ip_dest_o (m_ipd), .m_hdr_ip_src_o (m_ips),
    .m_hdr_port_dest_o (m_ppd), .m_hdr_port_src_o (m_pps),
    .m_tdata_o (m_td), .m_tkeep_o (m_tk), .m_tlast_o (m_tl), .m_tvld_o (m_tvld),
    .m_trdy_i (m_trdy), .grant_o (grant)
  );

  for (genvar g = 0; g < NS; g++) begin : g_map
    assign s_ipd[g]  = hd_ipd[g];
    assign s_ips[g]  = hd_ips[g];
    assign s_ppd[g]  = hd_ppd[g];
    assign s_pps[g]  = hd_pps[g];
    assign s_td[g]   = td_u[g];
    assign s_tk[g]   = tk_u[g];
    assign s_tl[g]   = tl_u[g];
    assign s_tv[g]   = tv_u[g];
    assign trdy_u[g] = s_trdy[g];
  end

  beat_t       srcq [NS][$];
  beat_t       out_log [$];
  logic [31:0] out_ipd [$];
  logic [15:0] out_ppd [$];
  int          out_cyc [$];
  int          grant_log [$];
  logic [NS-1:0] prev_g = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: owner index, last winner and a one-deep output register
  bit          mbusy = 1'b0;
  int          mown = 0;
  int          mlast = NS - 1;
  bit          mvld = 1'b0;
  beat_t       mbeat = '0;
  logic [31:0] mipd = '0, mips = '0;
  logic [15:0] mppd = '0, mpps = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_list(input string nm, input int got[$], input int exp[$]);
    chk({nm, "_len"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk(nm, 64'(got[i]), 64'(exp[i]));
  endtask

  function automatic logic [NS-1:0] onehot(input int i);
    return NS'(1) << i;
  endfunction

  function automatic bit bitof(input logic [NS-1:0] v, input int i);
    return |(v & onehot(i));
  endfunction

  function automatic int oh2i(input logic [NS-1:0] v);
    for (int i = 0; i < NS; i++) if (bitof(v, i)) return i;
    return -1;
  endfunction

  function automatic int pick(input logic [NS-1:0] r, input int last);
`ifdef UDP_ARB_PRIO0_EN
    if (bitof(r, 0)) return 0;
`endif
    for (int j = 1; j <= NS; j++) if (bitof(r, (last + j) % NS)) return (last + j) % NS;
    return -1;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      chk("s_trdy", 64'(s_trdy), 64'((mbusy && (!mvld || m_trdy)) ? onehot(mown) : '0));
      chk("grant", 64'(grant), 64'(mbusy ? onehot(mown) : '0));
      chk("m_tvld", 64'(m_tvld), 64'(mvld));
      if (mvld) begin
        chk("m_tdata", 64'(m_td), 64'(mbeat.d));
        chk("m_tkeep", 64'(m_tk), 64'(mbeat.k));
        chk("m_tlast", 64'(m_tl), 64'(mbeat.l));
        chk("m_ip_dest", 64'(m_ipd), 64'(mipd));
        chk("m_ip_src", 64'(m_ips), 64'(mips));
        chk("m_port_dest", 64'(m_ppd), 64'(mppd));
        chk("m_port_src", 64'(m_pps), 64'(mpps));
      end
      if (m_tvld && m_trdy) begin
        out_log.push_back({m_td, m_tk, m_tl});
        out_ipd.push_back(m_ipd);
        out_ppd.push_back(m_ppd);
        out_cyc.push_back(cyc);
      end
      if (grant != '0 && grant != prev_g) grant_log.push_back(oh2i(grant));
      prev_g = grant;
      for (int i = 0; i < NS; i++) rdy_seen[i] = trdy_u[i];
    end
  end

  always @(posedge clk) begin
    bit take;
    int w;
    if (reset_n) begin
      take = mbusy && tv_u[mown] && (!mvld || m_trdy);
      if (take) begin
        mvld  = 1'b1;
        mbeat = {td_u[mown], tk_u[mown], tl_u[mown]};
        mipd  = hd_ipd[mown];
        mips  = hd_ips[mown];
        mppd  = hd_ppd[mown];
        mpps  = hd_pps[mown];
      end else if (m_trdy) begin
        mvld = 1'b0;
      end
      if (mbusy) begin
        if (take && tl_u[mown]) begin
          mbusy = 1'b0;
          mlast = mown;
        end
      end else begin
        w = pick(s_tv, mlast);
        if (w >= 0) begin
          mbusy = 1'b1;
          mown  = w;
        end
      end
    end
    #1;
    for (int i = 0; i < NS; i++) begin
      if (reset_n && tv_u[i] && rdy_seen[i]) void'(srcq[i].pop_front());
      tv_u[i] = (srcq[i].size() > 0) && !hold[i];
      if (srcq[i].size() > 0) begin
        td_u[i] = srcq[i][0].d;
        tk_u[i] = srcq[i][0].k;
        tl_u[i] = srcq[i][0].l;
      end else begin
        td_u[i] = '0;
        tk_u[i] = '0;
        tl_u[i] = 1'b0;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_pkt(input int src, input int n, input logic [31:0] base, input logic [3:0] keep);
    for (int w = 0; w < n; w++) srcq[src].push_back({base + 32'(w), keep, (w == n - 1)});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m_trdy  = 1'b1;
    for (int i = 0; i < NS; i++) begin
      srcq[i].delete();
      hold[i] = 1'b0;
    end
    mbusy = 1'b0; mown = 0; mlast = NS - 1; mvld = 1'b0;
    out_log.delete(); out_ipd.delete(); out_ppd.delete(); out_cyc.delete();
    grant_log.delete();
    prev_g = '0;
    wait_cyc(2);
    reset_n = 1'b1;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    bit busy = 1'b1;
    while (busy && n < 200) begin
      wait_cyc(1);
      n++;
      busy = mbusy || mvld;
      for (int i = 0; i < NS; i++) if (srcq[i].size() > 0) busy = 1'b1;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", nm, n);
    end
  endtask

  initial begin
    int e[$];
    int n;
    logic [31:0] snap;
    for (int i = 0; i < NS; i++) begin
      hd_ipd[i] = 32'h0A00_0000 + 32'(i);
      hd_ips[i] = 32'h0B00_0000 + 32'(i);
      hd_ppd[i] = 16'h1000 + 16'(i);
      hd_pps[i] = 16'h2000 + 16'(i);
      hold[i] = 1'b0;
      tv_u[i] = 1'b0; td_u[i] = '0; tk_u[i] = '0; tl_u[i] = 1'b0;
      rdy_seen[i] = 1'b0;
    end
    wait_cyc(2);
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_trdy", 64'(s_trdy), 64'(0));
    chk("rst_tvld", 64'(m_tvld), 64'(0));
    chk("rst_tdata", 64'(m_td), 64'(0));
    chk("rst_tlast", 64'(m_tl), 64'(0));
    chk("rst_ip_dest", 64'(m_ipd), 64'(0));
    reset_n = 1'b1;

    // 3-word packet from source 2
    hd_ipd[2] = 32'hC0A8_0102;
    hd_ppd[2] = 16'h1F90;
    push_pkt(2, 3, 32'hA0A0_0001, 4'hF);
    wait_cyc(3);
    chk("t1_grant", 64'(grant), 64'(4'b0100));
    wait_done("t1");
    e = '{2};
    chk_list("t1_order", grant_log, e);
    chk("t1_beats", 64'(out_log.size()), 64'(3));
    for (int w = 0; w < 3 && w < out_log.size(); w++) begin
      chk("t1_data", 64'(out_log[w].d), 64'(32'hA0A0_0001 + 32'(w)));
      chk("t1_last", 64'(out_log[w].l), 64'(w == 2));
      chk("t1_ip_dest", 64'(out_ipd[w]), 64'(32'hC0A8_0102));
      chk("t1_port_dest", 64'(out_ppd[w]), 64'(16'h1F90));
    end

    // all sources busy, 2-word packets
    do_reset();
    push_pkt(0, 2, 32'h0A00_0000, 4'hF);
    push_pkt(0, 2, 32'h0A00_0010, 4'hF);
    push_pkt(1, 2, 32'h0A00_0100, 4'hF);
    push_pkt(2, 2, 32'h0A00_0200, 4'hF);
    push_pkt(3, 2, 32'h0A00_0300, 4'hF);
    wait_done("t2");
    e = '{0, 1, 2, 3, 0};
    chk_list("t2_order", grant_log, e);
    e = '{32'h0A00_0000, 32'h0A00_0001, 32'h0A00_0100, 32'h0A00_0101, 32'h0A00_0200,
          32'h0A00_0201, 32'h0A00_0300, 32'h0A00_0301, 32'h0A00_0010, 32'h0A00_0011};
    chk("t2_beats", 64'(out_log.size()), 64'(10));
    for (int i = 0; i < 10 && i < out_log.size(); i++) chk("t2_data", 64'(out_log[i].d), 64'(e[i]));
    if (out_cyc.size() == 10) chk("t2_span", 64'(out_cyc[9] - out_cyc[0]), 64'(13));

    // granted source 1 stalls while source 3 waits
    do_reset();
    push_pkt(1, 4, 32'h1111_0000, 4'hF);
    n = 0;
    while (srcq[1].size() > 2 && n < 30) begin wait_cyc(1); n++; end
    chk("t3_reach", 64'(n < 30), 64'(1));
    hold[1] = 1'b1;
    push_pkt(3, 2, 32'h3333_0000, 4'hF);
    for (int i = 0; i < 5; i++) begin
      wait_cyc(1);
      chk("t3_grant", 64'(grant), 64'(4'b0010));
      chk("t3_trdy3", 64'(trdy_u[3]), 64'(0));
    end
    hold[1] = 1'b0;
    wait_done("t3");
    e = '{1, 3};
    chk_list("t3_order", grant_log, e);
    chk("t3_beats", 64'(out_log.size()), 64'(6));
    if (out_log.size() == 6) begin
      chk("t3_last1", 64'(out_log[3].l), 64'(1));
      chk("t3_first3", 64'(out_log[4].d), 64'(32'h3333_0000));
    end

    // downstream backpressure for 4 cycles
    do_reset();
    push_pkt(0, 6, 32'h4000_0000, 4'hF);
    n = 0;
    while (out_log.size() < 2 && n < 30) begin wait_cyc(1); n++; end
    chk("t4_reach", 64'(n < 30), 64'(1));
    m_trdy = 1'b0;
    snap = m_td;
    for (int i = 0; i < 4; i++) begin
      wait_cyc(1);
      chk("t4_hold_data", 64'(m_td), 64'(snap));
      chk("t4_hold_vld", 64'(m_tvld), 64'(1));
      chk("t4_trdy", 64'(s_trdy), 64'(0));
    end
    m_trdy = 1'b1;
    wait_done("t4");
    chk("t4_beats", 64'(out_log.size()), 64'(6));
    for (int i = 0; i < 6 && i < out_log.size(); i++)
      chk("t4_data", 64'(out_log[i].d), 64'(32'h4000_0000 + 32'(i)));

    // single-word packets from sources 0 and 1
    do_reset();
    push_pkt(0, 1, 32'h5000_0000, 4'h3);
    push_pkt(0, 1, 32'h5000_0001, 4'h3);
    push_pkt(1, 1, 32'h5100_0000, 4'h3);
    push_pkt(1, 1, 32'h5100_0001, 4'h3);
    wait_done("t5");
    e = '{0, 1, 0, 1};
    chk_list("t5_order", grant_log, e);
    chk("t5_beats", 64'(out_log.size()), 64'(4));
    for (int i = 0; i < out_log.size(); i++) begin
      chk("t5_keep", 64'(out_log[i].k), 64'(4'h3));
      chk("t5_last", 64'(out_log[i].l), 64'(1));
    end

    // sources 0 and 2 contend
    do_reset();
    push_pkt(0, 2, 32'h6000_0000, 4'hF);
    push_pkt(0, 2, 32'h6000_0010, 4'hF);
    push_pkt(0, 2, 32'h6000_0020, 4'hF);
    push_pkt(2, 2, 32'h6200_0000, 4'hF);
    wait_done("t6");
`ifdef UDP_ARB_PRIO0_EN
    e = '{0, 0, 0, 2};
`else
    e = '{0, 2, 0, 0};
`endif
    chk_list("t6_order", grant_log, e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_tx_arbiter.md
# udp_tx_arbiter

Packet-level arbiter that shares one UDP transmit datapath (length/checksum stage, then the IP/MAC stack) between `N_SRC` independent user sources. Each source presents an AXI-Stream payload with its UDP/IP header held alongside. The arbiter grants one source at a time for a whole packet and never interleaves words from different packets. It forwards the granted stream through one output register stage, with the header held stable for the full packet.

## Interface
- `N_SRC`, 4: number of requesting sources, 1..16.
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s_hdr_ip_dest_i`, `s_hdr_ip_src_i`  in  `N_SRC`x32  per-source IP addresses, stable while `s_tvld_i[i]`.
- `s_hdr_port_dest_i`, `s_hdr_port_src_i`  in  `N_SRC`x16  per-source UDP ports, stable while `s_tvld_i[i]`.
- `s_tdata_i`  in  `N_SRC`x32  payload words.
- `s_tkeep_i`  in  `N_SRC`x4  byte enables.
- `s_tlast_i`, `s_tvld_i`  in  `N_SRC`  last word / valid.
- `s_trdy_o`  out  `N_SRC`  per-source ready; one-hot or zero.
- `m_hdr_ip_dest_o`, `m_hdr_ip_src_o`  out  32  header to downstream.
- `m_hdr_port_dest_o`, `m_hdr_port_src_o`  out  16  header to downstream.
- `m_tdata_o`  out  32.
- `m_tkeep_o`  out  4.
- `m_tlast_o`  out  1.
- `m_tvld_o`  out  1.
- `m_trdy_i`  in  1  downstream ready.
- `grant_o`  out  `N_SRC`  one-hot current owner; zero in IDLE.

## Operation
- FSM states: IDLE and SEND.
- **IDLE**
  - `s_trdy_o` is 0.
  - If any `s_tvld_i` is set, pick a winner by round-robin: search starts at `last_winner+1` and wraps modulo `N_SRC`.
  - Latch the winner into `grant_o`, then go to SEND.
  - The header is not latched in this state.
- **SEND**
  - `s_trdy_o[g] = !m_tvld_o | m_trdy_i`. All other bits are 0.
  - On each accepted word (`s_tvld_i[g] & s_trdy_o[g]`), load `m_tdata/tkeep/tlast` and all four header fields from source g. Set `m_tvld_o` to 1.
  - When the accepted word has tlast, update `last_winner` to g, clear `grant_o`, and go to IDLE.
- **Output register.** If `m_trdy_i` is high while `m_tvld_o` is high and no new word is loaded, `m_tvld_o` drops to 0. Output data holds its value while `m_tvld_o & !m_trdy_i`.
- **Granted source stalls** (`s_tvld_i[g]` low mid-packet): the grant is kept and bubbles go downstream. Other sources wait; there is no timeout.
- **Single-word packet** (tlast on the first word): SEND lasts one accept, then back to IDLE.
- **`N_SRC`=1**: the arbiter degenerates to an IDLE/SEND pass-through with a 1-cycle gap per packet.
- **Reset values**: all outputs are 0, state is IDLE, `last_winner` is `N_SRC-1` so source 0 wins first.
- **Reset mid-packet**: the packet is truncated with no tlast. Downstream resets on the same `reset_n`.

## Timing
- Arbitration costs 1 cycle: a request seen in IDLE at cycle t gives `s_trdy_o` high at t+1.
- The first word is accepted at t+1 and appears on `m_*` at t+2.
- Data latency through the block is 1 cycle.
- Throughput is 1 word/cycle inside a packet. A back-to-back packet of W words occupies W+1 cycles.
- `s_trdy_o` depends combinationally on `m_trdy_i` through an AND gate only. No other source-to-sink combinational path exists.
- Simultaneous tlast acceptance and a new request: the new request is arbitrated in the following IDLE cycle, never in the same cycle.

## Configuration
- `UDP_ARB_PRIO0_EN` defined: source 0 has strict priority. In IDLE, if `s_tvld_i[0]` is set it wins regardless of `last_winner`. Sources 1..`N_SRC-1` rotate round-robin among themselves. An active packet is still never preempted.
- Undefined: plain round-robin over all sources.

## Structure
- Package `udp_pkg`:
  - `udp_hdr_t` packed struct {ip_dest[31:0], ip_src[31:0], port_dest[15:0], port_src[15:0]}.
  - `udp_axis_t` struct {tdata, tkeep, tlast}.
  - Constant `UDP_MAX_SRC` = 16.
- Sub-module `rr_arbiter #(N)`:
  - Inputs: `req[N]`, `last_winner`.
  - Outputs: one-hot `gnt[N]`, `gnt_idx`, `any`.
  - Purely combinational. The `UDP_ARB_PRIO0_EN` masking lives here.

## Test plan
- Reset, then source 2 sends 3 words 0xA0A0_0001..3 with tlast on word 3 and header ip_dest 0xC0A8_0102 / port_dest 0x1F90 -> `grant_o`=0b0100. Words appear on `m_*` in order, header is constant on all 3, `m_tlast_o` is set on word 3 only.
- All 4 sources request continuously with 2-word packets -> grant order 0,1,2,3,0. No words interleave. There is exactly one gap cycle between packets.
- Granted source 1 drops `s_tvld_i` for 5 cycles mid-packet while source 3 requests -> `grant_o` stays 0b0010, `s_trdy_o[3]`=0 throughout, source 3 is granted after source 1's tlast.
- `m_trdy_i` is held low for 4 cycles during a packet -> `m_*` outputs are held unchanged and `s_trdy_o` is 0. No word is lost or duplicated when `m_trdy_i` returns.
- Single-word packets (tkeep=0x3, tlast=1) from sources 0 and 1 -> each appears as one beat with tkeep=0x3. Grants alternate.
- With `UDP_ARB_PRIO0_EN` defined, sources 0 and 2 request continuously -> source 0 wins every arbitration. Source 2 is served only when source 0's `s_tvld_i` is low in IDLE.
